serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_fa_bit.sv | 24 ++
 rtl/serial_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width helper. Imported by the RTL and by the testbench.
package serial_adder_pkg;

  // Controller states of the serial adder.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  // Bit counter width; a single-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder built from two half-adder stages. Purely combinational;
// the carry storage lives in the serial_adder controller.
module serial_fa_bit (
  input  logic a_bit,
  input  logic b_bit,
  input  logic c_in,
  output logic s_bit,
  output logic c_next
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder combines the operand bits, second folds in the carry.
  always_comb begin
    ha0_sum   = a_bit ^ b_bit;
    ha0_carry = a_bit & b_bit;
    s_bit     = ha0_sum ^ c_in;
    ha1_carry = ha0_sum & c_in;
    c_next    = ha0_carry | ha1_carry;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured on start, then one bit per
// clock is added LSB first. The result appears on sum/cout with a one-cycle
// done pulse and is held until the next result completes.
//
// Handshake: start is only looked at while idle (busy=0, done=0); the edge
// that sees start=1 captures a and b. busy is high for WIDTH cycles while
// bits are processed, then done pulses for one cycle with sum/cout valid from
// that cycle on. Start during busy or done is ignored.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_vec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_next;
  logic             last_bit;

  serial_fa_bit u_fa (
    .a_bit  (a_sr_q[0]),
    .b_bit  (b_sr_q[0]),
    .c_in   (carry_q),
    .s_bit  (s_bit),
    .c_next (c_next)
  );

  assign last_bit = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept start only when idle, leave RUN after the last bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; busy/done are registered from the next state.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    s_vec   = '0;
    s_vec[WIDTH-1] = s_bit;
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        // New bits enter at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
        acc_d   = (acc_q >> 1) | s_vec;
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d  = acc_d;
          cout_d = c_next;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
